// File: rtl/axis_frame_rr_arbiter.sv
// Purpose : frame-level round-robin arbiter that drives bus_sel of a 4:1 AXI-Stream mux.
// Latency : grant appears 1 cycle after the request is seen; in_tready is combinational from out_tready.
// Backpres: in_tready of the granted channel follows out_tready; a stalled grant is released by a watchdog.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   arb_en                     allow new grants (the current frame always completes)
//   in_tvalid[3:0], in_tlast   per-decoder stream handshake inputs
//   out_tready                 tready of the downstream FIFO slave port
//   bus_sel[3:0]               registered mux select code
//   in_tready[3:0]             per-decoder tready (only the granted bit can be 1)
//   busy                       a grant is held
//   err_timeout                one-cycle pulse when the watchdog drops a grant
//   frame_cnt_0..3             completed frames per channel, wrapping
module axis_frame_rr_arbiter #(
  parameter logic [3:0]  CHOOSE_FIFO_0   = 4'b0100,
  parameter logic [3:0]  CHOOSE_FIFO_1   = 4'b0101,
  parameter logic [3:0]  CHOOSE_FIFO_2   = 4'b0110,
  parameter logic [3:0]  CHOOSE_FIFO_3   = 4'b0111,
  parameter logic [3:0]  NON_FIFO_CHOOSE = 4'b0000,
  parameter int unsigned IDLE_TIMEOUT    = 256,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [3:0]       in_tvalid,
  input  logic [3:0]       in_tlast,
  input  logic             out_tready,
  output logic [3:0]       bus_sel,
  output logic [3:0]       in_tready,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] frame_cnt_0,
  output logic [CNT_W-1:0] frame_cnt_1,
  output logic [CNT_W-1:0] frame_cnt_2,
  output logic [CNT_W-1:0] frame_cnt_3
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  // Watchdog value at which a further idle cycle releases the grant.
  localparam logic [15:0]      WD_LAST = 16'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       g_q, g_d;
  logic [1:0]       last_q, last_d;
  logic [15:0]      wdog_q, wdog_d;
  logic [3:0]       bus_sel_q, bus_sel_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic             found;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             xfer;

  function automatic logic [3:0] sel_code(input logic [1:0] ch);
    case (ch)
      2'd0:    sel_code = CHOOSE_FIFO_0;
      2'd1:    sel_code = CHOOSE_FIFO_1;
      2'd2:    sel_code = CHOOSE_FIFO_2;
      default: sel_code = CHOOSE_FIFO_3;
    endcase
  endfunction

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && in_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    bus_sel_d = bus_sel_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
    in_tready = 4'b0000;
    xfer      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_en && found) begin
          state_d   = ST_GRANT;
          g_d       = pick;
          bus_sel_d = sel_code(pick);
          busy_d    = 1'b1;
          wdog_d    = 16'd0;
        end
      end
      ST_GRANT: begin
        in_tready[g_q] = out_tready;
        xfer           = in_tvalid[g_q] & out_tready;
        if (xfer && in_tlast[g_q]) begin
          // End of frame wins over a simultaneous watchdog expiry.
          state_d    = ST_IDLE;
          bus_sel_d  = NON_FIFO_CHOOSE;
          busy_d     = 1'b0;
          last_d     = g_q;
          cnt_d[g_q] = cnt_q[g_q] + CNT_ONE;
        end else if (xfer) begin
          wdog_d = 16'd0;
        end else if (wdog_q == WD_LAST) begin
          // Drop the stalled frame; it is not counted.
          state_d   = ST_IDLE;
          bus_sel_d = NON_FIFO_CHOOSE;
          busy_d    = 1'b0;
          last_d    = g_q;
          err_d     = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      g_q       <= 2'd0;
      last_q    <= 2'd3;
      wdog_q    <= 16'd0;
      bus_sel_q <= NON_FIFO_CHOOSE;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      bus_sel_q <= bus_sel_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus_sel     = bus_sel_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign frame_cnt_0 = cnt_q[0];
  assign frame_cnt_1 = cnt_q[1];
  assign frame_cnt_2 = cnt_q[2];
  assign frame_cnt_3 = cnt_q[3];

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// Purpose : randomized + directed bench for axis_frame_rr_arbiter against a frame-level reference model.
// Latency : model predicts registered outputs one cycle after each decision.
// Backpres: out_tready is randomized and forced low in directed stall scenarios.
module tb_axis_frame_rr_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_en;
  logic [3:0]  in_tvalid, in_tlast;
  logic        out_tready;
  logic [3:0]  bus_sel, in_tready;
  logic        busy, err_timeout;
  logic [15:0] frame_cnt_0, frame_cnt_1, frame_cnt_2, frame_cnt_3;

  axis_frame_rr_arbiter #(.IDLE_TIMEOUT(T), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast), .out_tready(out_tready),
    .bus_sel(bus_sel), .in_tready(in_tready), .busy(busy), .err_timeout(err_timeout),
    .frame_cnt_0(frame_cnt_0), .frame_cnt_1(frame_cnt_1),
    .frame_cnt_2(frame_cnt_2), .frame_cnt_3(frame_cnt_3)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which channel owns the bus (-1 = none), whose turn is next,
  // how long the current frame has gone without moving, and frames seen per channel.
  int m_gnt, m_last, m_stall, m_beats, m_err;
  int m_cnt [4];
  logic [3:0] prev_sel;
  logic [3:0] glog [$];

  function automatic logic [3:0] code(input int ch);
    return (ch < 0) ? 4'b0000 : 4'(4 + ch);
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_last = 3; m_stall = 0; m_beats = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    prev_sel = 4'b0000;
  endtask

  task automatic check_outputs();
    logic [3:0] rdy;
    rdy = 4'b0000;
    if (m_gnt >= 0 && out_tready) rdy[m_gnt] = 1'b1;
    chk("bus_sel", bus_sel, code(m_gnt));
    chk("busy", busy, m_gnt >= 0);
    chk("err_timeout", err_timeout, m_err);
    chk("in_tready", in_tready, rdy);
    chk("frame_cnt_0", frame_cnt_0, m_cnt[0] & 16'hFFFF);
    chk("frame_cnt_1", frame_cnt_1, m_cnt[1] & 16'hFFFF);
    chk("frame_cnt_2", frame_cnt_2, m_cnt[2] & 16'hFFFF);
    chk("frame_cnt_3", frame_cnt_3, m_cnt[3] & 16'hFFFF);
  endtask

  task automatic model_step();
    m_err = 0;
    if (m_gnt < 0) begin
      if (arb_en && in_tvalid != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_gnt < 0 && in_tvalid[(m_last + k) % 4]) m_gnt = (m_last + k) % 4;
        end
        m_stall = 0;
        m_beats = 0;
      end
    end else if (in_tvalid[m_gnt] && out_tready) begin
      m_stall = 0;
      m_beats++;
      if (in_tlast[m_gnt]) begin
        m_cnt[m_gnt]++;
        m_last = m_gnt;
        m_gnt  = -1;
      end
    end else begin
      m_stall++;
      if (m_stall == T) begin
        m_err  = 1;
        m_last = m_gnt;
        m_gnt  = -1;
      end
    end
  endtask

  task automatic step(input logic a, input logic [3:0] v, input logic [3:0] l, input logic r);
    @(negedge clk);
    arb_en = a; in_tvalid = v; in_tlast = l; out_tready = r;
    #1;
    check_outputs();
    if (bus_sel != 4'b0000 && prev_sel == 4'b0000) glog.push_back(bus_sel);
    prev_sel = bus_sel;
    model_step();
  endtask

  // Asserts reset away from a clock edge, checks the immediate effect, releases on a negedge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    arb_en = 1'b0; in_tvalid = 4'b0000; in_tlast = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pv, pr;
    logic [3:0] v, l;
    rst_n = 1'b0; arb_en = 1'b0; in_tvalid = '0; in_tlast = '0; out_tready = 1'b0;
    model_reset();
    do_reset();

    // 3-beat frame on channel 0.
    step(1, 4'b0001, 4'b0000, 1);
    step(1, 4'b0001, 4'b0000, 1);
    chk("t1_sel", bus_sel, 4'b0100);
    step(1, 4'b0001, 4'b0000, 1);
    step(1, 4'b0001, 4'b0001, 1);
    step(1, 4'b0000, 4'b0000, 1);
    chk("t1_sel_idle", bus_sel, 4'b0000);
    chk("t1_cnt0", frame_cnt_0, 1);

    // All channels requesting, 2-beat frames: round-robin order.
    do_reset();
    glog.delete();
    for (int i = 0; i < 13; i++) step(1, 4'hF, (m_beats == 1 && m_gnt >= 0) ? 4'hF : 4'h0, 1);
    chk("t2_cnt0", frame_cnt_0, 1);
    chk("t2_cnt1", frame_cnt_1, 1);
    chk("t2_cnt2", frame_cnt_2, 1);
    chk("t2_cnt3", frame_cnt_3, 1);
    step(1, 4'hF, 4'h0, 1);
    chk("t2_ngrants", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("t2_order", glog[i], 4'(4 + (i % 4)));

    // Channel 2 stalled by out_tready for 5 cycles.
    do_reset();
    step(1, 4'b0100, 4'b0000, 1);
    step(1, 4'b0100, 4'b0000, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b0100, 4'b0000, 0);
      chk("t3_rdy", in_tready, 4'b0000);
      chk("t3_sel", bus_sel, 4'b0110);
    end
    step(1, 4'b0100, 4'b0100, 1);
    step(1, 4'b0000, 4'b0000, 1);
    chk("t3_cnt2", frame_cnt_2, 1);

    // Watchdog on channel 1, channel 2 waiting.
    do_reset();
    step(1, 4'b0010, 4'b0000, 1);
    step(1, 4'b0010, 4'b0000, 1);
    for (int i = 0; i < T; i++) step(1, 4'b0100, 4'b0000, 1);
    step(1, 4'b0100, 4'b0000, 1);
    chk("t4_err", err_timeout, 1);
    chk("t4_sel", bus_sel, 4'b0000);
    chk("t4_cnt1", frame_cnt_1, 0);
    step(1, 4'b0100, 4'b0000, 1);
    chk("t4_err_clr", err_timeout, 0);
    chk("t4_regrant", bus_sel, 4'b0110);

    // arb_en dropped mid-frame on channel 3.
    do_reset();
    step(1, 4'b1000, 4'b0000, 1);
    step(1, 4'b1000, 4'b0000, 1);
    step(0, 4'b1011, 4'b0000, 1);
    step(0, 4'b1011, 4'b1000, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b0011, 4'b0000, 1);
      chk("t5_nogrant", bus_sel, 4'b0000);
    end
    chk("t5_cnt3", frame_cnt_3, 1);
    step(1, 4'b0011, 4'b0000, 1);
    step(1, 4'b0011, 4'b0000, 1);
    chk("t5_grant", bus_sel, 4'b0100);

    // Async reset in the middle of channel 0's frame.
    step(1, 4'b0011, 4'b0000, 1);
    out_tready = 1'b1;
    do_reset();
    chk("t6_rdy", in_tready, 4'b0000);
    chk("t6_cnt3", frame_cnt_3, 0);
    step(1, 4'b0110, 4'b0000, 1);
    step(1, 4'b0110, 4'b0000, 1);
    chk("t6_first", bus_sel, 4'b0101);

    // Randomized phases with varying valid/ready density.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin pv = 80; pr = 90; end
        1: begin pv = 50; pr = 50; end
        2: begin pv = 15; pr = 30; end
        default: begin pv = 95; pr = 10; end
      endcase
      for (int c = 0; c < 1000; c++) begin
        for (int b = 0; b < 4; b++) begin
          v[b] = ($urandom_range(99) < pv);
          l[b] = ($urandom_range(99) < 30);
        end
        if ($urandom_range(999) == 0) do_reset();
        step($urandom_range(9) != 0, v, l, $urandom_range(99) < pr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
